// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// Latency: n/a (wires only).
// Backpressure: n/a; the controller answers through the enables in the same cycle.
//
// master: datapath side. It drives the decode/execute observations and
//         receives the enables, state and counters.
// slave : hazard controller side.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        id_valid;
  logic [4:0]  ex_rd;
  logic [15:0] ex_flags;
  logic        ex_branch_taken;
  logic        if_wait;
  logic        pc_ena;
  logic        if_id_hold;
  logic        if_id_ena;
  logic        or_ena;
  logic [1:0]  state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_valid,
           ex_rd, ex_flags, ex_branch_taken, if_wait,
    input  pc_ena, if_id_hold, if_id_ena, or_ena, state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, id_valid,
           ex_rd, ex_flags, ex_branch_taken, if_wait,
    output pc_ena, if_id_hold, if_id_ena, or_ena, state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / taken-branch / fetch-wait hazard controller for PC, IF/ID and operand-read latch.
// Latency: enables are combinational from state and inputs (0 cycles); state and counters registered.
// Backpressure: stalls PC and holds IF/ID on load-use, kills the front end on branches, absorbs if_wait.
//
// Ports: clk, rst (synchronous, active high); hif (slave) carries IF/ID operand info,
// operand-read latch rd/flags, branch and fetch-wait inputs, and returns pc_ena,
// if_id_hold, if_id_ena, or_ena, debug state and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int FLAG_VALID   = 15,
  parameter int FLAG_LOAD    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LOAD_WAIT = 2'd1,
    FLUSH     = 2'd2
  } state_t;

  // The entry cycle is already the first bubble/kill, so the counter holds
  // the number of cycles still to come.
  localparam logic [2:0] LOAD_INIT  = 3'(LOAD_BUBBLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] stall_cnt_q, flush_cnt_q;

  logic ex_is_valid, branch_ev, load_haz, rs1_hit, rs2_hit;
  logic pc_ena_c, if_id_hold_c, if_id_ena_c, or_ena_c, flush_ev;

  assign ex_is_valid = hif.ex_flags[FLAG_VALID];
  assign branch_ev   = hif.ex_branch_taken & ex_is_valid;
  assign rs1_hit     = hif.id_uses_rs1 & (hif.id_rs1 == hif.ex_rd);
  assign rs2_hit     = hif.id_uses_rs2 & (hif.id_rs2 == hif.ex_rd);
  assign load_haz    = ex_is_valid & hif.ex_flags[FLAG_LOAD] & (hif.ex_rd != 5'd0)
                     & hif.id_valid & (rs1_hit | rs2_hit);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_ena_c     = 1'b0;
    if_id_hold_c = 1'b0;
    if_id_ena_c  = 1'b0;
    or_ena_c     = 1'b0;
    flush_ev     = 1'b0;
    case (state_q)
      LOAD_WAIT: begin
        // Front end is frozen and EX holds a bubble: nothing else is looked at.
        if_id_hold_c = 1'b1;
        cnt_d        = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      end
      FLUSH: begin
        pc_ena_c = ~hif.if_wait;
        cnt_d    = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) begin
          state_d = RUN;
          cnt_d   = 3'd0;
        end
      end
      default: begin
        // RUN, and the unused encoding which recovers to RUN.
        state_d = RUN;
        if (branch_ev) begin
          pc_ena_c = 1'b1;
          flush_ev = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_INIT;
          end
        end else if (load_haz) begin
          if_id_hold_c = 1'b1;
          if (LOAD_BUBBLES > 1) begin
            state_d = LOAD_WAIT;
            cnt_d   = LOAD_INIT;
          end
        end else if (hif.if_wait) begin
          // Older instruction still advances into operand read.
          or_ena_c = 1'b1;
        end else begin
          pc_ena_c    = 1'b1;
          if_id_ena_c = 1'b1;
          or_ena_c    = 1'b1;
        end
      end
    endcase
    if (rst) begin
      pc_ena_c     = 1'b0;
      if_id_hold_c = 1'b0;
      if_id_ena_c  = 1'b0;
      or_ena_c     = 1'b0;
      flush_ev     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= 3'd0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pc_ena_c && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (flush_ev && flush_cnt_q != 16'hFFFF)
        flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign hif.pc_ena     = pc_ena_c;
  assign hif.if_id_hold = if_id_hold_c;
  assign hif.if_id_ena  = if_id_ena_c;
  assign hif.or_ena     = or_ena_c;
  assign hif.state      = state_q;
  assign hif.stall_cnt  = stall_cnt_q;
  assign hif.flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Two controllers run side by side from the same stimulus: A with default
// parameters, B with LOAD_BUBBLES=3 and FLUSH_CYCLES=2.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs1, id_uses_rs2, id_valid, ex_branch_taken, if_wait;
  logic [15:0] ex_flags;

  int total = 0;
  int bad   = 0;
  bit quiet = 1'b0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hif_a ();
  pipeline_hazard_ctrl_if hif_b ();

  assign hif_a.id_rs1 = id_rs1;             assign hif_b.id_rs1 = id_rs1;
  assign hif_a.id_rs2 = id_rs2;             assign hif_b.id_rs2 = id_rs2;
  assign hif_a.id_uses_rs1 = id_uses_rs1;   assign hif_b.id_uses_rs1 = id_uses_rs1;
  assign hif_a.id_uses_rs2 = id_uses_rs2;   assign hif_b.id_uses_rs2 = id_uses_rs2;
  assign hif_a.id_valid = id_valid;         assign hif_b.id_valid = id_valid;
  assign hif_a.ex_rd = ex_rd;               assign hif_b.ex_rd = ex_rd;
  assign hif_a.ex_flags = ex_flags;         assign hif_b.ex_flags = ex_flags;
  assign hif_a.ex_branch_taken = ex_branch_taken;
  assign hif_b.ex_branch_taken = ex_branch_taken;
  assign hif_a.if_wait = if_wait;           assign hif_b.if_wait = if_wait;

  pipeline_hazard_ctrl dut_a (.clk(clk), .rst(rst), .hif(hif_a.slave));
  pipeline_hazard_ctrl #(.LOAD_BUBBLES(3), .FLUSH_CYCLES(2)) dut_b (.clk(clk), .rst(rst), .hif(hif_b.slave));

  // Reference model: mode 0 = running, 1 = load bubbles pending, 2 = flush
  // pending; rem = cycles still owed after the current one.
  int lb [2] = '{1, 3};
  int fc [2] = '{1, 2};
  int m_mode [2];
  int m_rem [2];
  int m_stall [2];
  int m_flush [2];

  function automatic bit f_branch();
    return ex_branch_taken && ex_flags[15];
  endfunction

  function automatic bit f_haz();
    bit hit;
    hit = (id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd);
    return ex_flags[15] && ex_flags[0] && ex_rd != 0 && id_valid && hit;
  endfunction

  // Expected {pc_ena, if_id_hold, if_id_ena, or_ena}; if_id_ena is a don't-care while holding.
  function automatic logic [3:0] f_out(int k);
    if (rst) return 4'b0000;
    if (m_mode[k] == 1) return 4'b0100;
    if (m_mode[k] == 2) return {!if_wait, 3'b000};
    if (f_branch()) return 4'b1000;
    if (f_haz()) return 4'b0100;
    if (if_wait) return 4'b0001;
    return 4'b1011;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int k);
    logic [3:0]  e;
    logic [3:0]  o;
    logic [1:0]  st;
    logic [15:0] sc, fcn;
    e = f_out(k);
    if (k == 0) begin
      o = {hif_a.pc_ena, hif_a.if_id_hold, hif_a.if_id_ena, hif_a.or_ena};
      st = hif_a.state; sc = hif_a.stall_cnt; fcn = hif_a.flush_cnt;
    end else begin
      o = {hif_b.pc_ena, hif_b.if_id_hold, hif_b.if_id_ena, hif_b.or_ena};
      st = hif_b.state; sc = hif_b.stall_cnt; fcn = hif_b.flush_cnt;
    end
    if (e[2]) begin
      o[1] = 1'b0;
      e[1] = 1'b0;
    end
    chk($sformatf("enables[%0d]@%0t", k, $time), 32'(o), 32'(e));
    chk($sformatf("state[%0d]@%0t", k, $time), 32'(st), 32'(m_mode[k]));
    chk($sformatf("stall_cnt[%0d]@%0t", k, $time), 32'(sc), 32'(m_stall[k]));
    chk($sformatf("flush_cnt[%0d]@%0t", k, $time), 32'(fcn), 32'(m_flush[k]));
  endtask

  task automatic model_edge(int k);
    logic [3:0] e;
    e = f_out(k);
    if (rst) begin
      m_mode[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
      return;
    end
    if (!e[3] && m_stall[k] < 65535) m_stall[k]++;
    if (m_mode[k] == 0) begin
      if (f_branch()) begin
        if (m_flush[k] < 65535) m_flush[k]++;
        if (fc[k] > 1) begin m_mode[k] = 2; m_rem[k] = fc[k] - 1; end
      end else if (f_haz()) begin
        if (lb[k] > 1) begin m_mode[k] = 1; m_rem[k] = lb[k] - 1; end
      end
    end else begin
      m_rem[k]--;
      if (m_rem[k] == 0) m_mode[k] = 0;
    end
  endtask

  // Inputs are already applied (we sit just after a falling edge).
  task automatic cycle();
    #1;
    if (!quiet) begin
      check_dut(0);
      check_dut(1);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    id_valid = 1'b0; ex_rd = 5'd0; ex_flags = 16'h0000;
    ex_branch_taken = 1'b0; if_wait = 1'b0;
  endtask

  task automatic load_hazard();
    ex_flags = 16'h8001; ex_rd = 5'd5; id_rs2 = 5'd5;
    id_uses_rs2 = 1'b1; id_valid = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_rem[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
    end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);

    // Reset with if_wait and a load hazard present.
    load_hazard();
    if_wait = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    idle_inputs();
    cycle();
    chk("after_reset_pc_a", 32'(hif_a.pc_ena), 32'd1);

    // Load-use hazard, then a clean pipe.
    load_hazard();
    cycle();
    idle_inputs();
    repeat (3) cycle();
    chk("load_stall_a", 32'(hif_a.stall_cnt), 32'd1);
    chk("load_stall_b", 32'(hif_b.stall_cnt), 32'd3);

    // Same stimulus with rd=x0, then with an invalid IF/ID slot: no stall.
    load_hazard(); ex_rd = 5'd0; id_rs2 = 5'd0;
    cycle();
    load_hazard(); id_valid = 1'b0;
    cycle();
    idle_inputs();
    cycle();
    chk("no_stall_b", 32'(hif_b.stall_cnt), 32'd3);

    // Branch and load hazard together: the flush wins.
    load_hazard(); ex_branch_taken = 1'b1;
    cycle();
    idle_inputs();
    repeat (2) cycle();
    chk("flush_cnt_b", 32'(hif_b.flush_cnt), 32'd1);
    chk("flush_stall_b", 32'(hif_b.stall_cnt), 32'd3);

    // Fetch wait in RUN for 4 cycles.
    if_wait = 1'b1;
    repeat (4) cycle();
    if_wait = 1'b0;
    cycle();
    chk("ifwait_stall_a", 32'(hif_a.stall_cnt), 32'd5);

    // Fetch wait during a flush: PC holds but the flush ends on count.
    ex_flags = 16'h8000; ex_branch_taken = 1'b1;
    cycle();
    idle_inputs(); if_wait = 1'b1;
    cycle();
    if_wait = 1'b0;
    repeat (2) cycle();
    chk("flush_done_b", 32'(hif_b.state), 32'd0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom_range(0, 49) == 0);
      id_rs1          = 5'($urandom_range(0, 3));
      id_rs2          = 5'($urandom_range(0, 3));
      ex_rd           = 5'($urandom_range(0, 3));
      id_uses_rs1     = 1'($urandom_range(0, 1));
      id_uses_rs2     = 1'($urandom_range(0, 1));
      id_valid        = ($urandom_range(0, 3) != 0);
      ex_flags        = 16'($urandom);
      ex_flags[15]    = ($urandom_range(0, 3) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      if_wait         = ($urandom_range(0, 4) == 0);
      cycle();
    end
    rst = 1'b0;

    // Reset in the second LOAD_WAIT cycle of B.
    idle_inputs();
    cycle();
    load_hazard();
    cycle();
    idle_inputs();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("rst_mid_state_b", 32'(hif_b.state), 32'd0);

    // Stall-counter saturation.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    if_wait = 1'b1;
    quiet = 1'b1;
    repeat (65534) cycle();
    quiet = 1'b0;
    if_wait = 1'b0;
    chk("sat_pre_a", 32'(hif_a.stall_cnt), 32'hFFFE);
    load_hazard();
    cycle();
    idle_inputs();
    repeat (3) cycle();
    chk("sat_a", 32'(hif_a.stall_cnt), 32'hFFFF);
    chk("sat_b", 32'(hif_b.stall_cnt), 32'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Hazard and stall controller that consumes the operand-read latch outputs (ex_rd, ex_flags) and generates that latch's enable plus the PC and IF/ID controls. It detects load-use hazards, inserts a parameterised number of bubbles, flushes the front end on taken branches, and absorbs instruction-fetch wait cycles. It also keeps saturating stall and flush performance counters. It sits beside the operand-read stage and drives the `ena` of the operand-read latch, where 0 means a bubble.

Parameters:
LOAD_BUBBLES, 1, bubbles inserted per load-use hazard (legal range 1..7)
FLUSH_CYCLES, 1, cycles the front end is killed after a taken branch (legal range 1..7)
FLAG_VALID, 15, ex_flags bit marking a real (non-bubble) instruction
FLAG_LOAD, 0, ex_flags bit marking a load

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active high
id_rs1  in  5  rs1 of the instruction in IF/ID
id_rs2  in  5  rs2 of the instruction in IF/ID
id_uses_rs1  in  1  IF/ID instruction reads rs1
id_uses_rs2  in  1  IF/ID instruction reads rs2
id_valid  in  1  IF/ID holds a real instruction
ex_rd  in  5  rd_out of the operand-read latch
ex_flags  in  16  flags_out of the operand-read latch
ex_branch_taken  in  1  branch or jump in EX resolved taken
if_wait  in  1  instruction memory not ready this cycle
pc_ena  out  1  1 = PC updates (sequential or branch target); 0 = PC holds
if_id_hold  out  1  1 = IF/ID keeps its current contents
if_id_ena  out  1  0 = IF/ID loads a bubble (ignored when if_id_hold=1)
or_ena  out  1  operand-read latch ena; 0 = bubble
state  out  2  current FSM state (debug)
stall_cnt  out  16  saturating count of cycles with pc_ena=0, reset excluded
flush_cnt  out  16  saturating count of taken-branch flush events

Behaviour:
- Clock/reset: one clock (clk); reset rst is synchronous and active-high.
- While rst=1:
  - outputs are pc_ena=0, if_id_hold=0, if_id_ena=0, or_ena=0.
  - On the edge: state<=RUN, internal counter<=0, stall_cnt<=0, flush_cnt<=0.
  - A reset mid-stall or mid-flush abandons it immediately.
- Control outputs are combinational from state and current inputs; state and counters are registered.
- States: RUN=0, LOAD_WAIT=1, FLUSH=2 (3 unused; if reached, decode as RUN and go to RUN next edge).
- ex_is_valid = ex_flags[FLAG_VALID].
- branch_ev = ex_branch_taken & ex_is_valid.
- load_haz = ex_is_valid & ex_flags[FLAG_LOAD] & (ex_rd!=0) & id_valid & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
- RUN, evaluated in priority order branch_ev > load_haz > if_wait:
  - branch_ev: pc_ena=1, if_id_hold=0, if_id_ena=0, or_ena=0; flush_cnt+1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; else stay in RUN.
  - load_haz: pc_ena=0, if_id_hold=1, or_ena=0. If LOAD_BUBBLES>1, go to LOAD_WAIT with cnt=LOAD_BUBBLES-1; else stay in RUN.
  - if_wait: pc_ena=0, if_id_hold=0, if_id_ena=0, or_ena=1 (older instruction proceeds).
  - none of the above: all enables 1, if_id_hold=0.
- LOAD_WAIT:
  - outputs pc_ena=0, if_id_hold=1, or_ena=0.
  - cnt decrements each cycle; go to RUN on the edge where cnt==1.
  - if_wait is ignored (front end already frozen).
  - branch_ev is ignored (EX holds a bubble).
- FLUSH:
  - outputs pc_ena=!if_wait, if_id_hold=0, if_id_ena=0, or_ena=0.
  - cnt decrements each cycle; go to RUN when cnt==1.
  - branch_ev and load_haz are ignored.
- Hazard checks are not repeated while the stall is in progress.
- Counters:
  - stall_cnt increments on every non-reset cycle with pc_ena=0; it saturates at 16'hFFFF, no wrap.
  - flush_cnt increments once per accepted branch_ev; it saturates at 16'hFFFF.
- Latency: every hazard response appears in the same cycle as the hazard; no extra cycle of latency.

Test Plan:
- Reset: assert rst for 2 cycles with if_wait=1 and a load hazard present -> all enables 0 and counters 0; on the first cycle after deassert with no hazard -> pc_ena=if_id_ena=or_ena=1, state=0.
- Load-use, default params: ex_flags=16'h8001, ex_rd=5, id_rs2=5, id_uses_rs2=1, id_valid=1 -> one cycle of pc_ena=0, if_id_hold=1, or_ena=0. Then with ex_flags=0 -> full run; stall_cnt=1.
- Load-use, LOAD_BUBBLES=3: same hazard -> exactly 3 consecutive stall cycles (state 1 for cycles 2-3) then RUN; stall_cnt=3. The same stimulus with ex_rd=0 or id_valid=0 -> no stall.
- Branch and load in the same cycle, FLUSH_CYCLES=2: branch_ev and load_haz together -> flush wins: pc_ena=1, if_id_ena=0, or_ena=0 for 2 cycles; flush_cnt=1; stall_cnt unchanged.
- if_wait in RUN: held for 4 cycles -> pc_ena=0, if_id_ena=0, or_ena=1 each cycle; stall_cnt=4. if_wait during FLUSH -> pc_ena=0 and the flush still completes on count.
- Saturation and reset mid-stall: preload stall_cnt to 16'hFFFE and stall 3 cycles -> stall_cnt stays 16'hFFFF. Assert rst in the second cycle of LOAD_WAIT -> state=0 and counters 0 next cycle.
